// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream master and its skid buffer.
package fifo_pkg;
  localparam int FIFO_DATA_WIDTH = 16;
  localparam int FIFO_PKT_LEN    = 8;
  localparam int SKID_DEPTH      = 2;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry circular skid buffer: captures FIFO read data, presents the head entry.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // the entries are reset too because the head entry drives m_data, which must read 0 in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_valid = (occ != 2'd0);
  assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side master: issues reads against buffer credit, hides the 1-cycle read
// latency behind a skid buffer and frames the output stream into PKT_LEN-word packets.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PKT_LEN    = FIFO_PKT_LEN,
  parameter int PCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_ren,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [7:0]            beat_idx,
  output logic [PCNT_WIDTH-1:0] pkt_cnt
);

  logic [1:0] occ;
  logic [2:0] credit;
  logic       inflight;
  logic       pop;
  logic       at_last;

  assign pop = m_valid & m_ready;

  // Words already buffered plus the one in flight, less the one leaving this cycle.
  assign credit   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_ren = rst & ~fifo_empty & ~flush & (credit < 3'(SKID_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inflight <= 1'b0;
    else      inflight <= fifo_ren;
  end

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (inflight),
    .push_data (fifo_dout),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data),
    .head_valid(m_valid)
  );

  assign at_last = (beat_idx == 8'(PKT_LEN - 1));
  // Gated by m_valid so the flag reads 0 in reset even when PKT_LEN is 1.
  assign m_last  = m_valid & at_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_idx <= 8'd0;
      pkt_cnt  <= '0;
    end else if (flush) begin
      beat_idx <= 8'd0;
    end else if (pop) begin
      if (at_last) begin
        beat_idx <= 8'd0;
        pkt_cnt  <= pkt_cnt + PCNT_WIDTH'(1);
      end else begin
        beat_idx <= beat_idx + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: a queue-based FIFO model feeds the DUT, a monitor checks every
// accepted beat against words read plus packet framing derived from beat counts.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int PKT_LEN = 8;

  logic       clk;
  logic       rst;
  logic       fifo_empty;
  fifo_word_t fifo_dout;
  logic       fifo_ren;
  logic       flush;
  fifo_word_t m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;
  logic [7:0] beat_idx;
  logic [15:0] pkt_cnt;

  logic       fifo_ren1;
  fifo_word_t fifo_dout1;
  fifo_word_t m_data1;
  logic       m_valid1;
  logic       m_last1;
  logic       m_ready1;
  logic [7:0] beat_idx1;
  logic [15:0] pkt_cnt1;

  fifo_rd_stream #(.DATA_WIDTH(16), .PKT_LEN(PKT_LEN), .PCNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_ren(fifo_ren), .flush(flush), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .beat_idx(beat_idx), .pkt_cnt(pkt_cnt)
  );

  fifo_rd_stream #(.DATA_WIDTH(16), .PKT_LEN(1), .PCNT_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .fifo_empty(1'b0), .fifo_dout(fifo_dout1),
    .fifo_ren(fifo_ren1), .flush(1'b0), .m_data(m_data1), .m_valid(m_valid1),
    .m_last(m_last1), .m_ready(m_ready1), .beat_idx(beat_idx1), .pkt_cnt(pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  fifo_word_t fifo_q[$];
  fifo_word_t exp_q[$];
  logic       ren_s;
  int         delivered = 0;
  int         since     = 0;
  int         pkt_base  = 0;

  // Monitor: inputs settle at negedge, so a handshake seen at negedge+2 completes at the next posedge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        exp_q.delete();
        since    = 0;
        pkt_base = 0;
      end else if (flush) begin
        exp_q.delete();
        pkt_base = pkt_base + since / PKT_LEN;
        since    = 0;
      end else if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 32'(m_valid), 32'd0);
        end else begin
          check("data", 32'(m_data), 32'(exp_q.pop_front()));
          check("beat_idx", 32'(beat_idx), 32'(since % PKT_LEN));
          check("last", 32'(m_last), 32'((since % PKT_LEN) == PKT_LEN - 1));
          check("pkt_cnt", 32'(pkt_cnt), 32'((pkt_base + since / PKT_LEN) & 16'hFFFF));
        end
        since++;
        delivered++;
      end
    end
  end

  // PKT_LEN=1 instance: endless incrementing source, random consumer.
  fifo_word_t exp1_q[$];
  fifo_word_t word1 = 16'h1000;
  int         beats1 = 0;
  logic       ren1_s;

  initial begin : len1_driver
    m_ready1   = 1'b0;
    fifo_dout1 = '0;
    forever begin
      @(negedge clk);
      m_ready1 = ($urandom_range(3) != 0);
      #1 ren1_s = fifo_ren1;
      #1;
      if (!rst) begin
        exp1_q.delete();
        beats1 = 0;
      end else if (m_valid1 && m_ready1) begin
        if (exp1_q.size() == 0) begin
          check("len1_spurious", 32'(m_valid1), 32'd0);
        end else begin
          check("len1_data", 32'(m_data1), 32'(exp1_q.pop_front()));
          check("len1_last", 32'(m_last1), 32'd1);
          check("len1_beat", 32'(beat_idx1), 32'd0);
          check("len1_pkt", 32'(pkt_cnt1), 32'(beats1 & 16'hFFFF));
        end
        beats1++;
      end
      @(posedge clk);
      #1;
      if (ren1_s) begin
        fifo_dout1 = word1;
        exp1_q.push_back(word1);
        word1 = word1 + 16'd1;
      end
    end
  end

  task automatic load(input fifo_word_t w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One cycle: drive inputs at negedge, sample the read request, model the FIFO's registered read.
  task automatic step(input logic rdy, input logic fl);
    @(negedge clk);
    m_ready = rdy;
    flush   = fl;
    #1;
    ren_s = fifo_ren;
    check("ren_while_empty", 32'(fifo_ren & fifo_empty), 32'd0);
    @(posedge clk);
    #1;
    if (ren_s && fifo_q.size() != 0) begin
      fifo_dout = fifo_q.pop_front();
      exp_q.push_back(fifo_dout);
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic random_phase(input int iters);
    for (int i = 0; i < iters; i++) begin
      if (fifo_q.size() < 3 && $urandom_range(1) == 1) load(16'($urandom));
      step($urandom_range(3) != 0, 1'b0);
    end
  endtask

  int first_ren;
  int d0;
  int tries;

  initial begin : stimulus
    rst = 1'b0; flush = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;

    // Reset, then idle with an empty FIFO
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check("rst_ren", 32'(fifo_ren), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_beat", 32'(beat_idx), 32'd0);
      check("rst_pkt", 32'(pkt_cnt), 32'd0);
      check("rst_data", 32'(m_data), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check("idle_ren", 32'(fifo_ren), 32'd0);
      check("idle_valid", 32'(m_valid), 32'd0);
    end

    // Streaming 16 words with the consumer always ready
    for (int i = 1; i <= 16; i++) load(16'(i));
    first_ren = -1;
    d0 = delivered;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0);
      if (ren_s && first_ren < 0) first_ren = i;
      if (first_ren >= 0 && i == first_ren)     check("lat_k1_valid", 32'(m_valid), 32'd0);
      if (first_ren >= 0 && i == first_ren + 1) check("lat_k2_valid", 32'(m_valid), 32'd1);
    end
    check("stream_first_ren", 32'(first_ren), 32'd0);
    check("stream_beats", 32'(delivered - d0), 32'd16);
    check("stream_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // Backpressure: stall 5 cycles, then drain
    for (int i = 0; i < 4; i++) load(16'hA0 + 16'(i));
    d0 = delivered;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      if (i >= 1) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_hold", 32'(m_data), 32'h00A0);
      end
    end
    check("bp_ren_drop", 32'(fifo_ren), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    check("bp_beats", 32'(delivered - d0), 32'd4);

    // Restart framing, then FIFO runs empty after 3 reads
    step(1'b1, 1'b1);
    d0 = delivered;
    for (int i = 0; i < 3; i++) load(16'h40 + 16'(i));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    check("empty_beats", 32'(delivered - d0), 32'd3);
    check("empty_beat_idx", 32'(beat_idx), 32'd3);
    check("empty_flag", 32'(fifo_empty), 32'd1);

    // Flush with a read in flight and one word buffered
    load(16'hB0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    load(16'hB1);
    step(1'b0, 1'b0);
    check("fl_ren_before", 32'(ren_s), 32'd1);
    step(1'b0, 1'b1);
    check("fl_ren_during", 32'(ren_s), 32'd0);
    check("fl_valid", 32'(m_valid), 32'd0);
    check("fl_beat", 32'(beat_idx), 32'd0);
    check("fl_pkt", 32'(pkt_cnt), 32'd2);
    d0 = delivered;
    load(16'hC0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    check("fl_after_beats", 32'(delivered - d0), 32'd1);

    // Random traffic, asynchronous reset after 5 more beats
    d0 = delivered;
    tries = 0;
    while (delivered - d0 < 5 && tries < 200) begin
      random_phase(1);
      tries++;
    end
    check("pre_reset_beats_reached", 32'(delivered - d0 >= 5), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid), 32'd0);
    check("arst_data", 32'(m_data), 32'd0);
    check("arst_last", 32'(m_last), 32'd0);
    check("arst_beat", 32'(beat_idx), 32'd0);
    check("arst_pkt", 32'(pkt_cnt), 32'd0);
    check("arst_ren", 32'(fifo_ren), 32'd0);
    check("arst_valid1", 32'(m_valid1), 32'd0);
    check("arst_pkt1", 32'(pkt_cnt1), 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    random_phase(80);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    check("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    check("drain_fifo_empty", 32'(fifo_q.size()), 32'd0);
    check("len1_activity", 32'(beats1 > 5), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
